// File: rtl/seg_display_scan_if.sv
// Interface between the stopwatch digit source and the 4-digit seven-segment scanner.
// The master drives the digits and adjust controls; the slave drives the display pins.
interface seg_display_scan_if;
    logic       adj;
    logic       sel;
    logic [3:0] minutes_top_digit;
    logic [3:0] minutes_bot_digit;
    logic [3:0] seconds_top_digit;
    logic [3:0] seconds_bot_digit;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    modport master (
        output adj, sel, minutes_top_digit, minutes_bot_digit,
               seconds_top_digit, seconds_bot_digit,
        input  an, seg, dp
    );

    modport slave (
        input  adj, sel, minutes_top_digit, minutes_bot_digit,
               seconds_top_digit, seconds_bot_digit,
        output an, seg, dp
    );
endinterface

// File: rtl/seg_display_scan.sv
// Time-multiplexed 4-digit common-anode display driver with adjust-mode pair blinking.
// Optional leading-zero suppression of the minutes tens digit: SEG_DISPLAY_SCAN_LEADING_ZERO_BLANK_EN.
module seg_display_scan #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BLINK_DIV   = 25000000
) (
    input logic               clk,
    input logic               rst,
    seg_display_scan_if.slave bus
);
    localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [RW-1:0] refresh_cnt;
    logic [1:0]    idx;
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;

    logic [3:0]    digit_c;
    logic          blank_c;
    logic [6:0]    seg_c;
    logic [3:0]    an_c;
    logic          dp_c;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    // Scan timing: each digit index held for REFRESH_DIV cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_cnt <= '0;
            idx         <= 2'd0;
        end else if (refresh_cnt == RW'(REFRESH_DIV - 1)) begin
            refresh_cnt <= '0;
            idx         <= idx + 2'd1;
        end else begin
            refresh_cnt <= refresh_cnt + RW'(1);
        end
    end

    // Blink timebase, parked at zero outside adjust mode so each entry starts visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (!bus.adj) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + BW'(1);
        end
    end

    always_comb begin
        digit_c = 4'd0;
        blank_c = 1'b0;
        case (idx)
            2'd0:    digit_c = bus.seconds_bot_digit;
            2'd1:    digit_c = bus.seconds_top_digit;
            2'd2:    digit_c = bus.minutes_bot_digit;
            default: digit_c = bus.minutes_top_digit;
        endcase
        // idx[1] set means a minutes slot; sel=0 selects minutes.
        blank_c = bus.adj && blink_phase && (idx[1] == ~bus.sel);
`ifdef SEG_DISPLAY_SCAN_LEADING_ZERO_BLANK_EN
        if (!bus.adj && (idx == 2'd3) && (bus.minutes_top_digit == 4'd0))
            blank_c = 1'b1;
`endif
        an_c  = blank_c ? 4'b1111 : ~(4'b0001 << idx);
        seg_c = blank_c ? 7'b1111111 : bcd_to_seg(digit_c);
        dp_c  = blank_c ? 1'b1 : (idx != 2'd2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.an  <= 4'b1111;
            bus.seg <= 7'b1111111;
            bus.dp  <= 1'b1;
        end else begin
            bus.an  <= an_c;
            bus.seg <= seg_c;
            bus.dp  <= dp_c;
        end
    end
endmodule

// File: tb/tb_seg_display_scan.sv
// Directed self-checking bench for seg_display_scan (REFRESH_DIV=4, BLINK_DIV=16).
module tb_seg_display_scan;
    logic clk;
    logic rst;
    seg_display_scan_if bus();

    seg_display_scan #(.REFRESH_DIV(4), .BLINK_DIV(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pos;   // output position within a 16-cycle scan: slot*4 + cycle
    int bcnt;  // clock edges seen with adj=1 since adj last rose
    logic       adj_v;
    logic       sel_v;
    logic [3:0] dg [4];

    function automatic logic [6:0] dec(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic drive();
        bus.adj               = adj_v;
        bus.sel               = sel_v;
        bus.minutes_top_digit = dg[3];
        bus.minutes_bot_digit = dg[2];
        bus.seconds_top_digit = dg[1];
        bus.seconds_bot_digit = dg[0];
    endtask

    // One clock with model prediction of the registered outputs, checked at the falling edge.
    task automatic tick(input string tag);
        int nxt;
        int slot;
        logic blank;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic e_dp;
        nxt   = (pos + 1) % 16;
        slot  = nxt / 4;
        blank = adj_v && (((bcnt / 16) % 2) == 1) && (sel_v ? (slot < 2) : (slot >= 2));
`ifdef SEG_DISPLAY_SCAN_LEADING_ZERO_BLANK_EN
        if (!adj_v && slot == 3 && dg[3] == 4'd0) blank = 1'b1;
`endif
        e_an  = blank ? 4'b1111 : ~(4'b0001 << slot);
        e_seg = blank ? 7'b1111111 : dec(dg[slot]);
        e_dp  = blank ? 1'b1 : (slot != 2);
        bcnt  = adj_v ? bcnt + 1 : 0;
        pos   = nxt;
        @(negedge clk);
        chk({tag, "_an"},  7'(bus.an), 7'(e_an));
        chk({tag, "_seg"}, bus.seg, e_seg);
        chk({tag, "_dp"},  7'(bus.dp), 7'(e_dp));
    endtask

    initial begin
        rst   = 1'b1;
        adj_v = 1'b0;
        sel_v = 1'b0;
        dg[3] = 4'd1; dg[2] = 4'd2; dg[1] = 4'd3; dg[0] = 4'd4;
        drive();
        pos = 15;
        bcnt = 0;
        repeat (3) @(negedge clk);
        chk("rst_an",  7'(bus.an), 7'(4'b1111));
        chk("rst_seg", bus.seg, 7'b1111111);
        chk("rst_dp",  7'(bus.dp), 7'(1'b1));

        // Scan order after release: slot 0 first, 4 clocks per slot
        rst = 1'b0;
        tick("scan");
        chk("first_an",  7'(bus.an), 7'(4'b1110));
        chk("first_seg", bus.seg, 7'b0011001);
        chk("first_dp",  7'(bus.dp), 7'(1'b1));
        repeat (3) tick("scan");
        chk("slot0_last_an", 7'(bus.an), 7'(4'b1110));
        tick("scan");
        chk("slot1_an",  7'(bus.an), 7'(4'b1101));
        chk("slot1_seg", bus.seg, 7'b0110000);
        repeat (4) tick("scan");
        chk("slot2_an",  7'(bus.an), 7'(4'b1011));
        chk("slot2_seg", bus.seg, 7'b0100100);
        chk("slot2_dp",  7'(bus.dp), 7'(1'b0));
        repeat (4) tick("scan");
        chk("slot3_an",  7'(bus.an), 7'(4'b0111));
        chk("slot3_seg", bus.seg, 7'b1111001);
        repeat (4) tick("scan");
        chk("wrap_an",   7'(bus.an), 7'(4'b1110));

        // Invalid BCD shows a dash; a mid-slot change shows one clock later
        dg[0] = 4'hC; drive();
        tick("dash");
        chk("dash_seg", bus.seg, 7'b0111111);
        dg[0] = 4'd7; drive();
        tick("midslot");
        chk("midslot_seg", bus.seg, 7'b1111000);
        dg[0] = 4'd4; drive();

        // Blink seconds pair: 16 lit, 16 blanked, 16 lit
        adj_v = 1'b1; sel_v = 1'b1; drive();
        for (int k = 1; k <= 48; k++) tick("blink_sec");

        // Switch to minutes pair while in blanked phase
        sel_v = 1'b0; drive();
        for (int i = 0; i < 16 && pos != 8; i++) tick("blink_min");
        chk("min_blank_an", 7'(bus.an), 7'(4'b1111));
        chk("min_blank_dp", 7'(bus.dp), 7'(1'b1));
        adj_v = 1'b0; drive();
        tick("adj_drop");
        chk("adj_drop_an", 7'(bus.an), 7'(4'b1011));
        chk("adj_drop_dp", 7'(bus.dp), 7'(1'b0));

        // Re-entering adjust mode starts with a full visible half-period
        adj_v = 1'b1; drive();
        for (int k = 1; k <= 40; k++) tick("readj");

        // Leading zero on the minutes tens digit
        adj_v = 1'b0; drive();
        dg[3] = 4'd0; dg[2] = 4'd5; dg[1] = 4'd3; dg[0] = 4'd0; drive();
        for (int k = 0; k < 16; k++) begin
            tick("lz_idle");
            if (pos / 4 == 3) begin
`ifdef SEG_DISPLAY_SCAN_LEADING_ZERO_BLANK_EN
                chk("lz_idle_an3", 7'(bus.an), 7'(4'b1111));
`else
                chk("lz_idle_an3", 7'(bus.an), 7'(4'b0111));
`endif
            end
        end
        adj_v = 1'b1; drive();
        for (int k = 0; k < 16; k++) begin
            tick("lz_adj");
            if (pos / 4 == 3) begin
                chk("lz_adj_an3",  7'(bus.an), 7'(4'b0111));
                chk("lz_adj_seg3", bus.seg, 7'b1000000);
            end
        end

        // Async reset mid-slot at index 2
        adj_v = 1'b0;
        dg[3] = 4'd1; dg[2] = 4'd2; dg[1] = 4'd3; dg[0] = 4'd4; drive();
        for (int i = 0; i < 16 && pos != 9; i++) tick("pre_rst");
        chk("pre_rst_an", 7'(bus.an), 7'(4'b1011));
        #2 rst = 1'b1;
        #1;
        chk("async_an",  7'(bus.an), 7'(4'b1111));
        chk("async_seg", bus.seg, 7'b1111111);
        chk("async_dp",  7'(bus.dp), 7'(1'b1));
        @(negedge clk);
        rst = 1'b0;
        pos = 15;
        bcnt = 0;
        for (int k = 0; k < 4; k++) begin
            tick("post_rst");
            chk("post_rst_an0", 7'(bus.an), 7'(4'b1110));
        end
        tick("post_rst");
        chk("post_rst_an1", 7'(bus.an), 7'(4'b1101));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
